// File: rtl/exec_muldiv_pkg.sv
// Shared RV32M encodings, FSM state type and small decode helpers for exec_muldiv.
package exec_muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b000_0001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // Divide family occupies the upper half of the funct3 space.
  function automatic logic op_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is read as a signed value for MULH, MULHSU, DIV and REM.
  function automatic logic op_rs1_signed(input logic [2:0] f3);
    return (f3 == INST_MULH) || (f3 == INST_MULHSU) ||
           (f3 == INST_DIV)  || (f3 == INST_REM);
  endfunction

  // rs2 is read as a signed value for MULH, DIV and REM.
  function automatic logic op_rs2_signed(input logic [2:0] f3);
    return (f3 == INST_MULH) || (f3 == INST_DIV) || (f3 == INST_REM);
  endfunction

endpackage

// File: rtl/exec_muldiv_step.sv
// One iteration of the iterative multiplier/divider datapath.
// Multiply: acc = {partial_hi, multiplier_remaining}; add operand when the
// current multiplier bit is set, then shift right by one.
// Divide: acc = {remainder, dividend/quotient}; shift left one bit into the
// remainder, subtract the divisor and keep the result if non-negative.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] div_rem;
  logic            div_bit;

  // Shift-add or restore-subtract for the current bit
  always_comb begin
    mul_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} +
                (acc_i[0] ? {1'b0, operand_i} : '0);
    div_shift = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    div_diff  = div_shift - {1'b0, operand_i};
    div_bit   = ~div_diff[XLEN];
    div_rem   = div_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    if (is_div) begin
      acc_o = {div_rem, acc_i[XLEN-2:0], div_bit};
    end else begin
      acc_o = {mul_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/exec_muldiv.sv
// Iterative RV32M multiply/divide unit. Stalls the pipeline via hold_en while
// computing and presents the rd value with a one-cycle done pulse.
module exec_muldiv
  import exec_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            hold_en,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept;
  logic              calc_last;
  logic              sign1, sign2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              is_special;
  logic [XLEN-1:0]   special_res;
  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   final_res;

  assign accept    = (state_q == ST_IDLE) && start && !flush;
  assign calc_last = (cnt_q == CNT_LAST);

  // Operand capture: signed views become magnitudes, special cases detected
  always_comb begin
    sign1 = op_rs1_signed(funct3) && rs1_data[XLEN-1];
    sign2 = op_rs2_signed(funct3) && rs2_data[XLEN-1];
    mag1  = sign1 ? -rs1_data : rs1_data;
    mag2  = sign2 ? -rs2_data : rs2_data;
    is_special  = 1'b0;
    special_res = '0;
    if (op_is_div(funct3)) begin
      if (rs2_data == '0) begin
        is_special  = 1'b1;
        special_res = funct3[1] ? rs1_data : '1;
      end else if (!funct3[0] && (rs1_data == MOST_NEG) && (rs2_data == '1)) begin
        is_special  = 1'b1;
        special_res = funct3[1] ? '0 : rs1_data;
      end
    end
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div    (op_is_div(op_q)),
    .acc_i     (acc_q),
    .operand_i (opd_q),
    .acc_o     (step_acc)
  );

  // Sign correction and result selection from the final iteration's output
  always_comb begin
    prod_signed = neg_q ? -step_acc : step_acc;
    quot        = step_acc[XLEN-1:0];
    rem         = step_acc[2*XLEN-1:XLEN];
    if (!op_is_div(op_q)) begin
      final_res = (op_q == INST_MUL) ? prod_signed[XLEN-1:0]
                                     : prod_signed[2*XLEN-1:XLEN];
    end else if (op_q[1]) begin
      final_res = rem_neg_q ? -rem : rem;
    end else begin
      final_res = neg_q ? -quot : quot;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush always returns to IDLE and drops any request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = is_special ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (calc_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    busy    = (state_q != ST_IDLE);
    hold_en = accept || (state_q == ST_CALC);
    done    = (state_q == ST_DONE) && !flush;
    result  = result_q;
  end

  // Datapath next values: capture in IDLE, iterate in CALC, commit on last step
  always_comb begin
    acc_d     = acc_q;
    opd_d     = opd_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    if (accept) begin
      op_d      = funct3;
      cnt_d     = '0;
      neg_d     = sign1 ^ sign2;
      rem_neg_d = sign1;
      if (op_is_div(funct3)) begin
        acc_d = {{XLEN{1'b0}}, mag1};
        opd_d = mag2;
      end else begin
        acc_d = {{XLEN{1'b0}}, mag2};
        opd_d = mag1;
      end
      if (is_special) begin
        result_d = special_res;
      end
    end else if ((state_q == ST_CALC) && !flush) begin
      acc_d = step_acc;
      cnt_d = cnt_q + 1'b1;
      if (calc_last) begin
        result_d = final_res;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      opd_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      acc_q     <= acc_d;
      opd_q     <= opd_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: doc/exec_muldiv.md
# exec_muldiv

Iterative RV32M multiply/divide unit, generalised to XLEN-bit operands, sitting beside the single-cycle execution stage. The execution stage asserts `start` for R-type instructions with funct7 = 7'b000_0001. This block stalls the pipeline through `hold_en` while it computes, then returns the rd value for one cycle. It covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, including the architectural divide-by-zero and overflow results.

## Interface
- `XLEN`, default 32: operand and result width; must be at least 4 and a power of two.
- `clk`  in  1  — the single clock; all state updates on its rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — request; sampled only in IDLE.
- `funct3`  in  3  — operation select (RV32M encoding, 000 = MUL … 111 = REMU).
- `rs1_data`  in  XLEN  — dividend / multiplicand.
- `rs2_data`  in  XLEN  — divisor / multiplier.
- `flush`  in  1  — ctrl jump flush; aborts any operation in progress.
- `busy`  out  1  — high when state ≠ IDLE.
- `hold_en`  out  1  — pipeline stall request to ctrl; combinational.
- `done`  out  1  — one-cycle pulse; `result` is valid while it is high.
- `result`  out  XLEN  — rd value; registered and held until the next `done`.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE → CALC on `start`.
  - IDLE → DONE on `start` with a special case (below).
  - CALC → DONE when the step counter reaches XLEN.
  - DONE → IDLE unconditionally.
- Operand capture in IDLE on `start`:
  - Signed views (MULH/MULHSU rs1, MULH rs2, DIV/REM both) are converted to magnitude.
  - Sign flags are latched for the final correction.
- Multiply: radix-2 shift-add on a 2·XLEN accumulator, one multiplier bit per CALC cycle.
  - MUL returns product[XLEN-1:0]; the MULH family returns product[2·XLEN-1:XLEN].
  - The product is negated when the operand signs differ.
- Divide: restoring division, one quotient bit per CALC cycle.
  - Quotient is negated when the signs differ; remainder takes the dividend's sign.
- Special cases skip CALC:
  - Divisor = 0: quotient = all ones, remainder = rs1.
  - Signed DIV/REM with rs1 = 1 followed by XLEN-1 zeros (most negative) and rs2 = all ones: quotient = rs1, remainder = 0.
- Step counter width is $clog2(XLEN)+1.
- `start` while busy is ignored (cannot occur under correct stall).
- `flush` in CALC or DONE → IDLE at the next edge; no `done` is issued and `result` is unchanged.
- `flush` and `start` together in IDLE: `flush` wins and the request is dropped.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, accumulators and counter 0. Reset mid-operation aborts immediately.
- Normal latency: `start` sampled at edge k → CALC for cycles k+1 … k+XLEN → `done` high in cycle k+XLEN+1 (34 cycles for XLEN=32).
- Special-case latency: `done` high in cycle k+1.
- `hold_en` = (state == IDLE && `start` && !`flush`) || state == CALC.
  - It is low in DONE, so the pipeline advances and writes `result` to rd in the same cycle `done` is high.
- `done` is exactly one cycle wide; back-to-back ops are possible from the cycle after DONE.

## Structure
- RV32M funct3 encodings (`INST_MUL` … `INST_REMU`) and funct7 `7'b000_0001` go in the shared defines header next to the existing instruction macros.
- One combinational sub-module, `muldiv_step`: a single shift-add or restore-subtract iteration, parametrised by XLEN and instantiated once.
- The FSM, sign handling and special-case detection stay in `exec_muldiv`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), start at cycle 0 → `hold_en` high cycles 0–32, `done` at cycle 33, `result` = 0xFFFFFFEB.
- High products, each with `done` after 34 cycles:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Special cases, each with `done` one cycle after start and no CALC:
  - DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- `flush` at cycle 10 of a DIV → IDLE at cycle 11, no `done`, `result` keeps its prior value. A new MUL 3 × 4 started at cycle 12 → 12.
- `rst_n` pulsed low mid-CALC → `busy`, `done` and `result` drop to 0 asynchronously. The next request after release completes with correct latency.
